multdiv_ctrl: RTL

- Sequences the shared iterative multiply/divide unit for the 5-stage pipeline.
- Sits beside the execute (X) stage and uses the decoded fields (op, alu_op, rd) of the instruction currently in X.
- On a mul/div it starts the unit, stalls F/D/X until the result is ready or a timeout expires, then issues one writeback request.
- On an exception or timeout, the writeback is redirected to the status register.

---
 rtl/multdiv_ctrl_if.sv | 30 +++
 rtl/multdiv_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/multdiv_ctrl_if.sv
// Handshake bundle between the X-stage controller and its driver: decoded
// X-stage fields and unit status in, start/stall/writeback controls out.
interface multdiv_ctrl_if;
  logic        x_valid;
  logic [4:0]  x_op;
  logic [4:0]  x_alu_op;
  logic [4:0]  x_rd;
  logic        unit_ready;
  logic        unit_exception;
  logic        start_mult;
  logic        start_div;
  logic        stall;
  logic        busy;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_sel_status;
  logic [31:0] wb_status;

  modport master (
    output x_valid, x_op, x_alu_op, x_rd, unit_ready, unit_exception,
    input  start_mult, start_div, stall, busy, wb_valid, wb_rd,
           wb_sel_status, wb_status
  );

  modport slave (
    input  x_valid, x_op, x_alu_op, x_rd, unit_ready, unit_exception,
    output start_mult, start_div, stall, busy, wb_valid, wb_rd,
           wb_sel_status, wb_status
  );
endinterface

// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared iterative mul/div unit: starts it, stalls F/D/X
// until ready or timeout, then issues a single writeback (status reg on error).
module multdiv_ctrl #(
  parameter int TIMEOUT    = 40,
  parameter int CNT_W      = 6,
  parameter int STATUS_REG = 30,
  parameter int MUL_STATUS = 4,
  parameter int DIV_STATUS = 5
) (
  input  logic          clock,
  input  logic          reset,
  multdiv_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);
  localparam logic [4:0]       OP_ALU  = 5'b00000;
  localparam logic [4:0]       ALU_MUL = 5'b00110;
  localparam logic [4:0]       ALU_DIV = 5'b00111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    WB   = 2'b10
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic [4:0]       r_rd;
  logic             r_start_mult;
  logic             r_start_div;
  logic             r_wb_valid;
  logic [4:0]       r_wb_rd;
  logic             r_wb_sel;
  logic [31:0]      r_wb_status;

  logic w_is_md;
  logic w_ready_ok;
  logic w_timeout;
  logic w_to_wb;
  logic w_exc;

  assign w_is_md = bus.x_valid && (bus.x_op == OP_ALU) &&
                   ((bus.x_alu_op == ALU_MUL) || (bus.x_alu_op == ALU_DIV));

  // A ready seen on the start cycle may belong to the previous operation.
  assign w_ready_ok = (r_state == WAIT) && (r_cnt != '0) && bus.unit_ready;
  assign w_timeout  = (r_state == WAIT) && (r_cnt == CNT_TO);
  assign w_to_wb    = w_ready_ok || w_timeout;
  assign w_exc      = w_ready_ok ? bus.unit_exception : 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_is_div     <= 1'b0;
      r_rd         <= '0;
      r_start_mult <= 1'b0;
      r_start_div  <= 1'b0;
      r_wb_valid   <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_sel     <= 1'b0;
      r_wb_status  <= '0;
    end else begin
      r_start_mult <= 1'b0;
      r_start_div  <= 1'b0;
      r_wb_valid   <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_sel     <= 1'b0;
      r_wb_status  <= '0;
      case (r_state)
        IDLE: begin
          if (w_is_md) begin
            r_is_div     <= bus.x_alu_op[0];
            r_rd         <= bus.x_rd;
            r_cnt        <= '0;
            r_start_mult <= !bus.x_alu_op[0];
            r_start_div  <= bus.x_alu_op[0];
            r_state      <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt != CNT_TO) r_cnt <= r_cnt + 1'b1;
          // Writeback fields are registered on entry so WB drives them glitch-free.
          if (w_to_wb) begin
            r_state     <= WB;
            r_wb_valid  <= w_exc || (r_rd != 5'd0);
            r_wb_rd     <= w_exc ? 5'(STATUS_REG) : r_rd;
            r_wb_sel    <= w_exc;
            r_wb_status <= !w_exc ? 32'd0 :
                           (r_is_div ? 32'(DIV_STATUS) : 32'(MUL_STATUS));
          end
        end
        WB:      r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Stall must rise in the detect cycle itself, so it stays combinational.
  assign bus.stall         = !reset && (((r_state == IDLE) && w_is_md) ||
                                        (r_state == WAIT));
  assign bus.busy          = (r_state != IDLE);
  assign bus.start_mult    = r_start_mult;
  assign bus.start_div     = r_start_div;
  assign bus.wb_valid      = r_wb_valid;
  assign bus.wb_rd         = r_wb_rd;
  assign bus.wb_sel_status = r_wb_sel;
  assign bus.wb_status     = r_wb_status;
endmodule
